// File: rtl/fizzbuzz_pkg.sv
// Shared types for the FizzBuzz token stream: token kinds, the buffered token
// record and the index-width helper used to size token values.
package fizzbuzz_pkg;

  // Storage width of a token value; tokenizers narrow it to their own index width.
  localparam int TOK_VALUE_W = 16;

  typedef enum logic [1:0] {
    TOK_NUM      = 2'd0,
    TOK_FIZZ     = 2'd1,
    TOK_BUZZ     = 2'd2,
    TOK_FIZZBUZZ = 2'd3
  } tok_kind_e;

  typedef struct packed {
    tok_kind_e               kind;
    logic [TOK_VALUE_W-1:0]  value;
  } token_t;

  localparam token_t TOKEN_NULL = '{kind: TOK_NUM, value: {TOK_VALUE_W{1'b0}}};

  function automatic int tok_value_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

  function automatic tok_kind_e classify(input logic fizz, input logic buzz,
                                         input logic fizzbuzz);
    tok_kind_e kind;
    if (fizzbuzz) begin
      kind = TOK_FIZZBUZZ;
    end else if (fizz) begin
      kind = TOK_FIZZ;
    end else if (buzz) begin
      kind = TOK_BUZZ;
    end else begin
      kind = TOK_NUM;
    end
    return kind;
  endfunction

endpackage

// File: rtl/fizzbuzz_tok_fifo.sv
// Synchronous token FIFO; a push is still accepted when full if a pop
// happens on the same edge.
module fizzbuzz_tok_fifo
  import fizzbuzz_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  token_t                 din,
  output token_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  token_t          mem_q [DEPTH];
  token_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == CW'(0));
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TOKEN_NULL;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fizzbuzz_tokenizer.sv
// Samples the FizzBuzz generator flags once per cycle, classifies each sample
// into an indexed token, buffers it and streams it out with status reporting.
module fizzbuzz_tokenizer
  import fizzbuzz_pkg::*;
#(
  parameter int FIZZ       = 3,
  parameter int BUZZ       = 5,
  parameter int MAX_CYCLES = 100,
  parameter int DEPTH      = 8
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    fizz,
  input  logic                                    buzz,
  input  logic                                    fizzbuzz,
  output logic                                    tok_valid,
  input  logic                                    tok_ready,
  output logic [1:0]                              tok_kind,
  output logic [tok_value_width(MAX_CYCLES)-1:0]  tok_value,
  output logic                                    overflow,
  output logic [7:0]                              drop_count,
  output logic                                    flag_err,
  output logic                                    done
);

  localparam int VW = tok_value_width(MAX_CYCLES);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FIZZ) + 1;
  localparam int BW = $clog2(BUZZ) + 1;
  localparam logic [VW-1:0] IDX_END   = VW'(MAX_CYCLES);
  localparam logic [FW-1:0] FIZZ_LAST = FW'(FIZZ - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ - 1);

  logic [VW-1:0] idx_q, idx_d;
  logic [FW-1:0] fz_cnt_q, fz_cnt_d;
  logic [BW-1:0] bz_cnt_q, bz_cnt_d;
  logic          flag_err_q, flag_err_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          done_q, done_d;

  logic          sample_s, push_s, pop_s, mismatch_s, empty_next_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  token_t        token_s, head_s;
  logic          unused_value_s;

  fizzbuzz_tok_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_s),
    .pop    (pop_s),
    .din    (token_s),
    .dout   (head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .count  (fifo_count_s)
  );

  // Sampling, classification, consistency check and drop accounting.
  always_comb begin
    sample_s      = (idx_q < IDX_END);
    pop_s         = ~fifo_empty_s & tok_ready;
    push_s        = sample_s & (~fifo_full_s | pop_s);
    token_s.kind  = classify(fizz, buzz, fizzbuzz);
    token_s.value = TOK_VALUE_W'(idx_q);
    // fz/bz counters track idx modulo FIZZ/BUZZ so no divider is needed.
    mismatch_s    = (fizzbuzz != (fizz & buzz)) ||
                    (fizz != (fz_cnt_q == FW'(0))) ||
                    (buzz != (bz_cnt_q == BW'(0)));
    if (sample_s) begin
      idx_d    = idx_q + VW'(1);
      fz_cnt_d = (fz_cnt_q == FIZZ_LAST) ? FW'(0) : fz_cnt_q + FW'(1);
      bz_cnt_d = (bz_cnt_q == BUZZ_LAST) ? BW'(0) : bz_cnt_q + BW'(1);
    end else begin
      idx_d    = idx_q;
      fz_cnt_d = fz_cnt_q;
      bz_cnt_d = bz_cnt_q;
    end
    flag_err_d = flag_err_q | (sample_s & mismatch_s);
    if (sample_s && !push_s) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_count_q == 8'd255) ? drop_count_q : drop_count_q + 8'd1;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
    // done is registered from next-state so it rises right after the final pop.
    case ({push_s, pop_s})
      2'b10:   empty_next_s = 1'b0;
      2'b01:   empty_next_s = (fifo_count_s == CW'(1));
      2'b11:   empty_next_s = 1'b0;
      default: empty_next_s = fifo_empty_s;
    endcase
    done_d = done_q | ((idx_d == IDX_END) & empty_next_s);
  end

  // Index, check counters and sticky status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q        <= {VW{1'b0}};
      fz_cnt_q     <= {FW{1'b0}};
      bz_cnt_q     <= {BW{1'b0}};
      flag_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      fz_cnt_q     <= fz_cnt_d;
      bz_cnt_q     <= bz_cnt_d;
      flag_err_q   <= flag_err_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      done_q       <= done_d;
    end
  end

  // Head token presentation; fields read as zero while nothing is buffered.
  always_comb begin
    tok_valid      = ~fifo_empty_s;
    unused_value_s = ^head_s.value;
    if (fifo_empty_s) begin
      tok_kind  = 2'd0;
      tok_value = {VW{1'b0}};
    end else begin
      tok_kind  = head_s.kind;
      tok_value = head_s.value[VW-1:0];
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign flag_err   = flag_err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fizzbuzz_tokenizer.sv
// Directed bench for fizzbuzz_tokenizer: drives a reference flag generator and
// scores the token stream against a small FIFO model and hand-computed values.
module tb_fizzbuzz_tokenizer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fizz, buzz, fizzbuzz;
  logic       tok_valid, tok_ready;
  logic [1:0] tok_kind;
  logic [7:0] tok_value;
  logic       overflow;
  logic [7:0] drop_count;
  logic       flag_err;
  logic       done;

  int n_chk = 0;
  int n_err = 0;

  int         n;               // bench copy of the sample index
  int         force_idx = -1;  // index at which fizzbuzz=1, buzz=0 is forced
  int         sb_bad;
  int         model_drops;
  logic [9:0] exp_q[$];
  logic [7:0] acc_v[$];
  logic [1:0] acc_k[$];

  fizzbuzz_tokenizer dut (
    .clk        (clk),
    .resetn     (resetn),
    .fizz       (fizz),
    .buzz       (buzz),
    .fizzbuzz   (fizzbuzz),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_kind   (tok_kind),
    .tok_value  (tok_value),
    .overflow   (overflow),
    .drop_count (drop_count),
    .flag_err   (flag_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    n = 0;
    sb_bad = 0;
    model_drops = 0;
    exp_q.delete();
    acc_v.delete();
    acc_k.delete();
  endtask

  task automatic reset_dut(input int cycles);
    resetn    = 1'b0;
    tok_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    clear_model();
    resetn = 1'b1;
  endtask

  // Called at a falling edge: drive inputs, score the handshake, advance one cycle.
  task automatic step(input logic rdy);
    logic       f, b, fb, pop;
    logic [1:0] k;
    logic [9:0] e;
    tok_ready = rdy;
    f  = (n % 3 == 0);
    b  = (n % 5 == 0);
    fb = f && b;
    if (n == force_idx) begin
      b  = 1'b0;
      fb = 1'b1;
    end
    fizz = f; buzz = b; fizzbuzz = fb;
    if (tok_valid !== (exp_q.size() > 0)) sb_bad++;
    pop = tok_valid && rdy;
    if (pop) begin
      acc_v.push_back(tok_value);
      acc_k.push_back(tok_kind);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if ({tok_kind, tok_value} !== e) sb_bad++;
      end else begin
        sb_bad++;
      end
    end
    if (n < 100) begin
      k = fb ? 2'd3 : (f ? 2'd1 : (b ? 2'd2 : 2'd0));
      if (exp_q.size() < 8) exp_q.push_back({k, 8'(n)});
      else model_drops++;
      n++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; tok_ready = 1'b0;
    fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", tok_valid, 0);
    check("rst_kind", tok_kind, 0);
    check("rst_value", tok_value, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
    check("rst_flag_err", flag_err, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;

    // Full-rate stream
    repeat (100) step(1'b1);
    check("t1_last_valid", tok_valid, 1);
    check("t1_last_value", tok_value, 99);
    check("t1_done_early", done, 0);
    step(1'b1);
    check("t1_done", done, 1);
    check("t1_count", acc_v.size(), 100);
    check("t1_tok0_kind", acc_k[0], 3);
    check("t1_tok0_value", acc_v[0], 0);
    check("t1_tok3_kind", acc_k[3], 1);
    check("t1_tok5_kind", acc_k[5], 2);
    check("t1_tok15_kind", acc_k[15], 3);
    check("t1_tok99_kind", acc_k[99], 1);
    check("t1_tok99_value", acc_v[99], 99);
    check("t1_flag_err", flag_err, 0);
    check("t1_overflow", overflow, 0);
    check("t1_drops", drop_count, 0);
    check("t1_scoreboard", sb_bad, 0);
    repeat (3) step(1'b1);
    check("t1_done_sticky", done, 1);

    // Stall, overflow, then a single-cycle pop while full
    reset_dut(2);
    step(1'b0);
    check("t2_latency_valid", tok_valid, 1);
    check("t2_latency_value", tok_value, 0);
    check("t2_latency_kind", tok_kind, 3);
    repeat (11) step(1'b0);
    check("t2_drops", drop_count, 4);
    check("t2_overflow", overflow, 1);
    check("t2_head_stable", tok_value, 0);
    step(1'b1);
    check("t3_pulse_drops", drop_count, 4);
    check("t3_pulse_head", tok_value, 1);
    step(1'b0);
    check("t3_still_full", drop_count, 5);
    repeat (120) step(1'b1);
    check("t2_after7", acc_v[8], 12);
    check("t3_after12", acc_v[9], 14);
    check("t2_count", acc_v.size(), 95);
    check("t2_drops_final", drop_count, 5);
    check("t2_done", done, 1);
    check("t2_scoreboard", sb_bad, 0);

    // Inconsistent flags at index 3
    reset_dut(2);
    force_idx = 3;
    repeat (3) step(1'b1);
    check("t4_err_before", flag_err, 0);
    step(1'b1);
    check("t4_err_set", flag_err, 1);
    repeat (10) step(1'b1);
    check("t4_err_sticky", flag_err, 1);
    check("t4_tok3_kind", acc_k[3], 3);
    check("t4_tok3_value", acc_v[3], 3);
    check("t4_scoreboard", sb_bad, 0);
    force_idx = -1;

    // Reset in the middle of a congested run
    reset_dut(2);
    repeat (40) step(1'b0);
    check("t5_pre_overflow", overflow, 1);
    check("t5_pre_drops", drop_count, 32);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_valid", tok_valid, 0);
    check("t5_kind", tok_kind, 0);
    check("t5_value", tok_value, 0);
    check("t5_overflow", overflow, 0);
    check("t5_drops", drop_count, 0);
    check("t5_flag_err", flag_err, 0);
    check("t5_done", done, 0);
    clear_model();
    resetn = 1'b1;
    repeat (2) step(1'b1);
    check("t5_first_kind", acc_k[0], 3);
    check("t5_first_value", acc_v[0], 0);

    // Random backpressure
    reset_dut(2);
    repeat (300) step(1'($urandom_range(0, 1)));
    check("t6_scoreboard", sb_bad, 0);
    check("t6_drops_model", drop_count, model_drops);
    check("t6_drops_missing", drop_count, 100 - acc_v.size());
    check("t6_overflow", overflow, (model_drops > 0) ? 1 : 0);
    check("t6_done", done, 1);
    check("t6_flag_err", flag_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fizzbuzz_tokenizer.md
# fizzbuzz_tokenizer

Downstream consumer of the FizzBuzz flag generator. It samples the generator's per-cycle `fizz`/`buzz`/`fizzbuzz` flags and numbers each sample with an internal index. Each sample becomes one classified token (kind plus index value), which is buffered in a small FIFO and presented on a valid/ready stream to the next stage (printer/scoreboard). It also reports FIFO overflow, flag-consistency errors and completion.

## Interface
- `FIZZ`, default 3: divisor for fizz; used only for the consistency check.
- `BUZZ`, default 5: divisor for buzz; used only for the consistency check.
- `MAX_CYCLES`, default 100: number of samples taken after reset, indices 0..MAX_CYCLES-1.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all logic on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `fizz`  in  1  upstream flag for the current index.
- `buzz`  in  1  upstream flag for the current index.
- `fizzbuzz`  in  1  upstream flag for the current index.
- `tok_valid`  out  1  head token available.
- `tok_ready`  in  1  consumer accepts the head token when `tok_valid && tok_ready`.
- `tok_kind`  out  2  0=NUM, 1=FIZZ, 2=BUZZ, 3=FIZZBUZZ.
- `tok_value`  out  $clog2(MAX_CYCLES)+1  index of the head token.
- `overflow`  out  1  sticky: at least one sample was dropped.
- `drop_count`  out  8  dropped samples, saturating at 255.
- `flag_err`  out  1  sticky: inconsistent flag combination seen.
- `done`  out  1  all MAX_CYCLES samples taken and FIFO empty.

## Operation
- Index counter `idx` resets to 0. It increments on every rising edge with `resetn` high while `idx < MAX_CYCLES`, then freezes (sampling stops).
- Sampling: at each such edge, the flags present on the inputs form sample `idx`. The first edge after reset release samples the generator's reset values (1,1,1) as index 0.
- Classification priority:
  - `fizzbuzz` → FIZZBUZZ
  - else `fizz` → FIZZ
  - else `buzz` → BUZZ
  - else NUM.
  - The token value is always `idx`.
- Consistency check: `flag_err` sets if any of the following holds. The token is still emitted.
  - `fizzbuzz != (fizz && buzz)`
  - `fizz != (idx % FIZZ == 0)`
  - `buzz != (idx % BUZZ == 0)`
- The check uses modulo counters, not dividers. A `%` operator on `idx` is forbidden.
- FIFO push: a sample is pushed if the FIFO is not full, or if it is full and a pop occurs on the same edge. Otherwise the sample is dropped: `overflow` sets and `drop_count` increments, saturating. `idx` advances whether or not the sample is pushed.
- Pop: `tok_valid && tok_ready`. The head token is stable while `tok_valid && !tok_ready`.
- `done` = (`idx == MAX_CYCLES`) && FIFO empty. Once high, `done` stays high until reset.
- Reset mid-operation: the FIFO is flushed, every counter and sticky flag clears, and the next edge samples index 0 again.

## Timing
- Reset values:
  - `tok_valid`=0, `tok_kind`=0, `tok_value`=0
  - `overflow`=0, `drop_count`=0, `flag_err`=0, `done`=0.
- Latency: a sample taken at edge E appears on `tok_*` with `tok_valid`=1 in the cycle after E, when the FIFO was empty. There is no combinational path from the flag inputs to any output.
- Throughput: 1 token/cycle with `tok_ready` held at 1. There is never a drop in that case.
- `tok_ready` combinationally affects only push/full, never `tok_valid`.
- `flag_err` and `overflow` are visible in the cycle after the offending edge.
- `done` rises the cycle after the final pop, or the cycle after the final sample if that sample was dropped and the FIFO is already empty.

## Structure
- Shared package `fizzbuzz_pkg`:
  - `tok_kind_e` enum (NUM, FIZZ, BUZZ, FIZZBUZZ)
  - `token_t` packed struct (kind, value)
  - a width function for `$clog2(MAX_CYCLES)+1`.
- Sub-module `fizzbuzz_tok_fifo`: a synchronous FIFO of `token_t`, parameterized by DEPTH, with full/empty/count and simultaneous push/pop when full. The top level contains the index, the check counters, classification, drop accounting and done.

## Test plan
- Reset, then `tok_ready`=1 with the generator at 3/5/100 → tokens in order: (FIZZBUZZ,0), (NUM,1), (NUM,2), (FIZZ,3), (NUM,4), (BUZZ,5), …, (FIZZBUZZ,15), …, (FIZZ,99). Exactly 100 tokens, `done` high after the last one, `flag_err`=0, `overflow`=0.
- `tok_ready`=0 for 12 cycles after reset, DEPTH=8 → tokens 0..7 retained, 4 samples dropped, `overflow`=1, `drop_count`=4. After `tok_ready` goes high, the next token after index 7 is index 12.
- FIFO full with `tok_ready` pulsed 1 for one cycle → the pop and the push occur on the same edge, `drop_count` is unchanged, and the count stays at 8.
- Force `fizzbuzz`=1 with `buzz`=0 at index 3 → the token is (FIZZBUZZ,3) and `flag_err`=1 from the next cycle, sticky.
- Assert `resetn` low at index 40 for 2 cycles, then release → FIFO empty, all status outputs 0, and the first token is (FIZZBUZZ,0).
- Backpressure with random `tok_ready` (50%), DEPTH=8 → the sequence of accepted tokens equals the reference sequence minus the dropped indices, and `drop_count` equals the number of missing indices.
